// File: rtl/bram1_req_server.sv
// rtl/bram1_req_server.sv - single-port BRAM request server with credit-limited read response queue
module bram1_req_server #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int PIPELINED  = 0,
    parameter int RESP_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_di,
    input  logic [DATA_WIDTH-1:0] bram_do
);

    localparam int STAGES = 1 + PIPELINED;
    localparam int PTR_W  = $clog2(RESP_DEPTH);
    localparam int CNT_W  = $clog2(RESP_DEPTH + 1);

    logic [STAGES-1:0]     inflight;
    logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      occupancy;
    logic [CNT_W-1:0]      inflight_cnt;
    logic [CNT_W:0]        outstanding;
    logic                  credit_ok;
    logic                  accept;
    logic                  rd_accept;
    logic                  enq;
    logic                  deq;

    // Credit counts reads still in the BRAM pipe plus queued responses, so the queue can never overflow.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < STAGES; i++) begin
            inflight_cnt = inflight_cnt + CNT_W'(inflight[i]);
        end
        outstanding = {1'b0, inflight_cnt} + {1'b0, occupancy};
        credit_ok   = outstanding < (CNT_W + 1)'(RESP_DEPTH);
    end

    assign req_ready = !RST && (req_we || credit_ok);
    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_we;

    assign bram_en   = accept;
    assign bram_we   = accept && req_we;
    assign bram_addr = req_addr;
    assign bram_di   = req_data;

    assign enq       = inflight[STAGES-1];
    assign rsp_valid = occupancy != '0;
    assign deq       = rsp_valid && rsp_ready;
    assign rsp_data  = fifo_mem[rd_ptr];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            inflight  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            inflight <= (inflight << 1) | STAGES'(rd_accept);
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // bram_do is captured on the edge its last pipe stage is marked, before any later write can disturb it.
    always_ff @(posedge CLK) begin
        if (enq) begin
            fifo_mem[wr_ptr] <= bram_do;
        end
    end

endmodule
